// File: rtl/stopwatch_datapath_pkg.sv
// Shared definitions for the stopwatch datapath: counter selector encodings,
// count range, and seven-segment patterns (active-low, bit 0 = segment a).
package stopwatch_datapath_pkg;

    localparam int CNT_W = 17;
    localparam logic [CNT_W-1:0] MAX_COUNT = 17'd9999;

    typedef enum logic [2:0] {
        CTR_TIMER_LD = 3'd0,
        CTR_UP       = 3'd1,
        CTR_DOWN     = 3'd2,
        CTR_SW_LD    = 3'd3
    } ctr_sel_e;

    localparam logic [6:0] SSEG_0     = 7'h40;
    localparam logic [6:0] SSEG_1     = 7'h79;
    localparam logic [6:0] SSEG_2     = 7'h24;
    localparam logic [6:0] SSEG_3     = 7'h30;
    localparam logic [6:0] SSEG_4     = 7'h19;
    localparam logic [6:0] SSEG_5     = 7'h12;
    localparam logic [6:0] SSEG_6     = 7'h02;
    localparam logic [6:0] SSEG_7     = 7'h78;
    localparam logic [6:0] SSEG_8     = 7'h00;
    localparam logic [6:0] SSEG_9     = 7'h10;
    localparam logic [6:0] SSEG_BLANK = 7'h7F;

    // Map one BCD digit to its segment pattern; non-decimal codes go blank.
    function automatic logic [6:0] sseg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SSEG_0;
            4'd1:    seg = SSEG_1;
            4'd2:    seg = SSEG_2;
            4'd3:    seg = SSEG_3;
            4'd4:    seg = SSEG_4;
            4'd5:    seg = SSEG_5;
            4'd6:    seg = SSEG_6;
            4'd7:    seg = SSEG_7;
            4'd8:    seg = SSEG_8;
            4'd9:    seg = SSEG_9;
            default: seg = SSEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/stopwatch_datapath_sseg_mux4.sv
// Four-digit multiplexed seven-segment driver: binary-to-BCD conversion,
// refresh divider, digit scan and registered anode/segment outputs.
module sseg_mux4
    import stopwatch_datapath_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             an_reset_i,
    output logic [3:0]       an_o,
    output logic [6:0]       sseg_o
);

    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    logic [REF_W-1:0] ref_q, ref_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       sseg_q, sseg_d;
    logic [15:0]      bcd;
    logic [3:0]       digit;

    // Double-dabble conversion; anything above 9999 is shown as 9999.
    always_comb begin
        logic [13:0] bin;
        logic [29:0] sh;
        bin = (value_i > MAX_COUNT) ? MAX_COUNT[13:0] : value_i[13:0];
        sh  = {16'd0, bin};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sh[14 + 4*d +: 4] >= 4'd5) begin
                    sh[14 + 4*d +: 4] = sh[14 + 4*d +: 4] + 4'd3;
                end
            end
            sh = sh << 1;
        end
        bcd = sh[29:14];
    end

    // Select the digit for the current scan position (index 0 = ones).
    always_comb begin
        case (idx_q)
            2'd0:    digit = bcd[3:0];
            2'd1:    digit = bcd[7:4];
            2'd2:    digit = bcd[11:8];
            default: digit = bcd[15:12];
        endcase
    end

    // Next-state for the refresh divider, scan index and display outputs.
    always_comb begin
        ref_d  = ref_q;
        idx_d  = idx_q;
        an_d   = 4'b1111;
        sseg_d = SSEG_BLANK;
        if (!an_reset_i) begin
            if (ref_q == REF_LAST) begin
                ref_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                ref_d = ref_q + REF_W'(1);
            end
            an_d   = ~(4'b0001 << idx_q);
            sseg_d = sseg_decode(digit);
        end else begin
            ref_d = '0;
        end
    end

    // Display state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            ref_q  <= '0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1111;
            sseg_q <= SSEG_BLANK;
        end else begin
            ref_q  <= ref_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
        end
    end

    assign an_o   = an_q;
    assign sseg_o = sseg_q;

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch/timer counting datapath: limit register, saturating up/down
// centisecond counter on a prescaled tick, terminal-count flag, display.
module stopwatch_datapath
    import stopwatch_datapath_pkg::*;
#(
    parameter int TICK_DIV    = 1_000_000,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_ld_en,
    input  logic             count_en,
    input  logic [2:0]       ctrSelect,
    input  logic [CNT_W-1:0] InitVal,
    input  logic             tcSelect,
    input  logic             anReset,
    output logic             tcLimitReached,
    output logic [3:0]       an,
    output logic [6:0]       sseg,
    output logic [CNT_W-1:0] synchInit
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick;

    assign tick = (presc_q == PRE_LAST);

    // Next-state for count, limit and prescaler; ctrSelect makes loads and
    // ticks mutually exclusive. Counting saturates at both ends.
    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        presc_d = presc_q;
        case (ctrSelect)
            CTR_TIMER_LD: begin
                if (init_ld_en) begin
                    limit_d = InitVal;
                    count_d = InitVal;
                    presc_d = '0;
                end
            end
            CTR_SW_LD: begin
                if (init_ld_en) begin
                    limit_d = InitVal;
                    count_d = '0;
                    presc_d = '0;
                end
            end
            CTR_UP: begin
                if (count_en) begin
                    presc_d = tick ? '0 : presc_q + PRE_W'(1);
                    if (tick && (count_q < limit_q) && (count_q < MAX_COUNT)) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            CTR_DOWN: begin
                if (count_en) begin
                    presc_d = tick ? '0 : presc_q + PRE_W'(1);
                    if (tick && (count_q != '0)) begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Counter, limit and prescaler registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            limit_q <= '0;
            presc_q <= '0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            presc_q <= presc_d;
        end
    end

    assign tcLimitReached = tcSelect ? (count_q == '0) : (count_q >= limit_q);
    assign synchInit      = limit_q;

    sseg_mux4 #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_sseg_mux4 (
        .clk       (clk),
        .rst_n_i   (reset),
        .value_i   (count_q),
        .an_reset_i(anReset),
        .an_o      (an),
        .sseg_o    (sseg)
    );

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Directed self-checking bench for stopwatch_datapath (TICK_DIV=4, REFRESH_DIV=2).
module tb_stopwatch_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_ld_en;
    logic        count_en;
    logic [2:0]  ctrSelect;
    logic [16:0] InitVal;
    logic        tcSelect;
    logic        anReset;
    logic        tcLimitReached;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic [16:0] synchInit;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    stopwatch_datapath #(
        .TICK_DIV   (4),
        .REFRESH_DIV(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init_ld_en    (init_ld_en),
        .count_en      (count_en),
        .ctrSelect     (ctrSelect),
        .InitVal       (InitVal),
        .tcSelect      (tcSelect),
        .anReset       (anReset),
        .tcLimitReached(tcLimitReached),
        .an            (an),
        .sseg          (sseg),
        .synchInit     (synchInit)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Advance n clock edges, ending 1 time unit after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the anode pattern matches, then record the check.
    task automatic wait_an(input string tag, input logic [3:0] target);
        int k;
        k = 0;
        while (an !== target && k < 20) begin
            step(1);
            k++;
        end
        check_eq(tag, 32'(an), 32'(target));
    endtask

    task automatic load(input logic [2:0] sel, input logic [16:0] val);
        ctrSelect  = sel;
        InitVal    = val;
        init_ld_en = 1'b1;
        step(1);
        init_ld_en = 1'b0;
        ctrSelect  = 3'd4;
    endtask

    initial begin
        reset = 1'b0; init_ld_en = 1'b0; count_en = 1'b0; ctrSelect = 3'd4;
        InitVal = 17'd0; tcSelect = 1'b0; anReset = 1'b1;

        // 1. reset
        step(2);
        check_eq("rst_count", 32'(dut.count_q), 32'd0);
        check_eq("rst_synchInit", 32'(synchInit), 32'd0);
        check_eq("rst_an", 32'(an), 32'hF);
        check_eq("rst_sseg", 32'(sseg), 32'h7F);
        check_eq("rst_tc_up", 32'(tcLimitReached), 32'd1);
        tcSelect = 1'b1; #1;
        check_eq("rst_tc_zero", 32'(tcLimitReached), 32'd1);
        tcSelect = 1'b0;
        reset = 1'b1;
        step(1);

        // 2. stopwatch from 0 toward 9999
        load(3'd3, 17'd9999);
        check_eq("sw_ld_synch", 32'(synchInit), 32'd9999);
        check_eq("sw_ld_count", 32'(dut.count_q), 32'd0);
        ctrSelect = 3'd1; count_en = 1'b1;
        step(40);
        check_eq("sw_up40", 32'(dut.count_q), 32'd10);
        check_eq("sw_up40_tc", 32'(tcLimitReached), 32'd0);

        // 3. timer countdown and zero saturation
        load(3'd0, 17'd3000);
        check_eq("tm_ld_synch", 32'(synchInit), 32'd3000);
        check_eq("tm_ld_count", 32'(dut.count_q), 32'd3000);
        ctrSelect = 3'd2; tcSelect = 1'b1;
        step(3);
        check_eq("tm_dn3", 32'(dut.count_q), 32'd3000);
        step(1);
        check_eq("tm_dn4", 32'(dut.count_q), 32'd2999);
        load(3'd0, 17'd2);
        ctrSelect = 3'd2;
        step(4);
        check_eq("tm2_dn4", 32'(dut.count_q), 32'd1);
        check_eq("tm2_dn4_tc", 32'(tcLimitReached), 32'd0);
        step(4);
        check_eq("tm2_dn8", 32'(dut.count_q), 32'd0);
        check_eq("tm2_dn8_tc", 32'(tcLimitReached), 32'd1);
        step(12);
        check_eq("tm2_sat", 32'(dut.count_q), 32'd0);
        check_eq("tm2_sat_tc", 32'(tcLimitReached), 32'd1);

        // 4. up to limit 5, with a pause that keeps the sub-tick phase
        tcSelect = 1'b0;
        load(3'd3, 17'd5);
        ctrSelect = 3'd1;
        step(10);
        check_eq("lim_pre_pause", 32'(dut.count_q), 32'd2);
        count_en = 1'b0;
        step(20);
        check_eq("lim_paused", 32'(dut.count_q), 32'd2);
        count_en = 1'b1;
        step(1);
        check_eq("lim_resume1", 32'(dut.count_q), 32'd2);
        step(1);
        check_eq("lim_resume2", 32'(dut.count_q), 32'd3);
        check_eq("lim_resume2_tc", 32'(tcLimitReached), 32'd0);
        step(40);
        check_eq("lim_stop", 32'(dut.count_q), 32'd5);
        check_eq("lim_stop_tc", 32'(tcLimitReached), 32'd1);
        count_en = 1'b0;

        // 5. display scan of 1234
        load(3'd0, 17'd1234);
        anReset = 1'b0;
        wait_an("disp_an0", 4'b1110);
        check_eq("disp_seg0", 32'(sseg), 32'h19);
        step(2);
        check_eq("disp_an1", 32'(an), 32'b1101);
        check_eq("disp_seg1", 32'(sseg), 32'h30);
        step(2);
        check_eq("disp_an2", 32'(an), 32'b1011);
        check_eq("disp_seg2", 32'(sseg), 32'h24);
        step(2);
        check_eq("disp_an3", 32'(an), 32'b0111);
        check_eq("disp_seg3", 32'(sseg), 32'h79);
        anReset = 1'b1;
        step(1);
        check_eq("blank_an", 32'(an), 32'hF);
        check_eq("blank_sseg", 32'(sseg), 32'h7F);

        // Values above 9999 display as 9999 and never count up
        load(3'd0, 17'd12000);
        anReset = 1'b0;
        wait_an("clamp_an0", 4'b1110);
        check_eq("clamp_seg0", 32'(sseg), 32'h10);
        step(6);
        check_eq("clamp_an3", 32'(an), 32'b0111);
        check_eq("clamp_seg3", 32'(sseg), 32'h10);
        ctrSelect = 3'd1; count_en = 1'b1;
        step(8);
        check_eq("clamp_up_hold", 32'(dut.count_q), 32'd12000);
        anReset = 1'b1;

        // 6. reset during countdown
        load(3'd0, 17'd3000);
        ctrSelect = 3'd2; count_en = 1'b1;
        step(6);
        reset = 1'b0;
        step(1);
        check_eq("rst2_count", 32'(dut.count_q), 32'd0);
        check_eq("rst2_synch", 32'(synchInit), 32'd0);
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
